adder_word_sequencer: RTL and testbench

//  Sequences one 8-bit ripple-carry adder slice to perform WORDS*8-bit add/subtract, one byte per cycle.

---
 rtl/adder_seq_pkg.sv | 15 +
 rtl/ripple_carry_adder8.sv | 21 ++
 rtl/adder_word_sequencer.sv | 140 ++++++++++++++
 tb/tb_adder_word_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// Shared constants and types for the byte-serial word adder.
package adder_seq_pkg;

  localparam int unsigned SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/ripple_carry_adder8.sv
// Combinational 8-bit ripple-carry adder slice.
module ripple_carry_adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[8];

endmodule

// File: rtl/adder_word_sequencer.sv
// Multi-byte add/subtract built from one 8-bit slice, processed LSB byte first,
// one byte per cycle, with valid/ready handshakes on both sides.
module adder_word_sequencer
  import adder_seq_pkg::*;
#(
  parameter  int unsigned WORDS = 4,
  localparam int unsigned W     = SLICE_W * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         busy
);

  localparam int unsigned         IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(WORDS - 1);

  state_t state, state_nxt;

  logic [IDX_W-1:0]                 idx, idx_nxt;
  logic                             carry, carry_nxt;
  logic [WORDS-1:0][SLICE_W-1:0]    a_q, a_nxt;
  logic [WORDS-1:0][SLICE_W-1:0]    b_q, b_nxt;
  logic [WORDS-1:0][SLICE_W-1:0]    sum_q, sum_nxt;
  logic                             cout_q, cout_nxt;
  logic                             ovf_q, ovf_nxt;
  logic                             in_ready_q, in_ready_nxt;
  logic                             out_valid_q, out_valid_nxt;
  logic                             busy_q, busy_nxt;

  logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
  logic               slice_cout;

  assign slice_a = a_q[idx];
  assign slice_b = b_q[idx];

  ripple_carry_adder8 u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      carry       <= carry_nxt;
      a_q         <= a_nxt;
      b_q         <= b_nxt;
      sum_q       <= sum_nxt;
      cout_q      <= cout_nxt;
      ovf_q       <= ovf_nxt;
      in_ready_q  <= in_ready_nxt;
      out_valid_q <= out_valid_nxt;
      busy_q      <= busy_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    carry_nxt = carry;
    a_nxt     = a_q;
    b_nxt     = b_q;
    sum_nxt   = sum_q;
    cout_nxt  = cout_q;
    ovf_nxt   = ovf_q;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          a_nxt     = in_a;
          b_nxt     = (in_sub == OP_SUB) ? ~in_b : in_b;
          carry_nxt = (in_sub == OP_SUB) ? 1'b1 : in_cin;
          idx_nxt   = '0;
          sum_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        sum_nxt[idx] = slice_sum;
        carry_nxt    = slice_cout;
        idx_nxt      = IDX_W'(idx + 1'b1);
        if (idx == LAST_IDX) begin
          cout_nxt  = slice_cout;
          // Final slice holds the sign bits; overflow uses the fresh MSB byte.
          ovf_nxt   = (a_q[WORDS-1][SLICE_W-1] == b_q[WORDS-1][SLICE_W-1]) &&
                      (slice_sum[SLICE_W-1] != a_q[WORDS-1][SLICE_W-1]);
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    in_ready_nxt  = (state_nxt == IDLE);
    out_valid_nxt = (state_nxt == DONE);
    busy_nxt      = (state_nxt != IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_word_sequencer.sv
// Directed scoreboard bench for adder_word_sequencer with WORDS=4.
module tb_adder_word_sequencer;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 8 * WORDS;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int   vectors = 0;
  int   errs    = 0;
  exp_t sb[$];

  adder_word_sequencer #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t         e;
    logic [W-1:0] bp;
    logic [W:0]   full;
    bp     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == bp[W-1]) && (e.sum[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub);
    int k;
    k = 0;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("accept_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    sb.push_back(model(a, b, cin, sub));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(k), 64'(WORDS));
  endtask

  task automatic take(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(0), 64'(1));
      return;
    end
    e = sb.pop_front();
    check({tag, "_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_sum"},   64'(out_sum),   64'(e.sum));
    check({tag, "_cout"},  64'(out_cout),  64'(e.cout));
    check({tag, "_ovf"},   64'(out_ovf),   64'(e.ovf));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'(0));
    check({tag, "_ready_back"}, 64'(in_ready),  64'(1));
  endtask

  initial begin
    exp_t e;
    logic saw_valid;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy",      64'(busy),      64'(0));
    check("rst_out_sum",   64'(out_sum),   64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check("run_busy", 64'(busy), 64'(1));
    wait_valid("lat_wrap");
    take("wrap");

    send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    wait_valid("lat_cin");
    take("cin");

    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_valid("lat_ovf");
    take("ovf");

    // Carry-in must be ignored on subtract.
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    wait_valid("lat_sub");
    take("sub");

    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    wait_valid("lat_subovf");
    take("subovf");

    // Backpressure: result held, no accept while DONE.
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    wait_valid("lat_bp");
    in_a = 32'hA5A5_0F0F; in_b = 32'h5A5A_F0F1; in_cin = 1'b0; in_sub = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid",    64'(out_valid), 64'(1));
      check("bp_in_ready", 64'(in_ready),  64'(0));
      check("bp_sum",      64'(out_sum),   64'(sb[0].sum));
    end
    e = sb.pop_front();
    check("bp_cout", 64'(out_cout), 64'(e.cout));
    check("bp_ovf",  64'(out_ovf),  64'(e.ovf));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_valid_drop", 64'(out_valid), 64'(0));
    check("bp_idle_ready", 64'(in_ready),  64'(1));
    @(posedge clk);
    sb.push_back(model(32'hA5A5_0F0F, 32'h5A5A_F0F1, 1'b0, 1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_busy", 64'(busy), 64'(1));
    wait_valid("lat_bp_next");
    take("bp_next");

    // Reset mid-operation discards the in-flight result.
    send(32'h0102_0304, 32'h1010_1010, 1'b0, 1'b0);
    void'(sb.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready",  64'(in_ready),  64'(1));
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_busy",      64'(busy),      64'(0));
    check("mid_rst_out_sum",   64'(out_sum),   64'(0));
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("mid_rst_no_pulse", 64'(saw_valid), 64'(0));

    send(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0);
    wait_valid("lat_post_rst");
    take("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
